hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes, data-memory wait freeze and bus-error timeout.
// Optional performance counters are enabled with the HAZARD_PERF_CNT_EN macro.
module hazard_ctrl #(
    parameter int MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_wreg,
    input  logic        ex_mem2reg,
    input  logic        branch_taken,
    input  logic        mem_req,
    input  logic        mem_ready,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        bubble,
    output logic        flush_ifid,
    output logic        freeze,
    output logic        bus_error,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [1:0]  dbg_state
);

    localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL_LU = 2'd1,
        WAIT_MEM = 2'd2,
        ERROR    = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          mem_wait;
    logic          load_use;

    // An access completes in the cycle mem_req and mem_ready are both high;
    // a dropped mem_req also ends the wait, so only req & ~ready holds the pipe.
    assign mem_wait = mem_req & ~mem_ready;
    assign load_use = ex_mem2reg & ex_wreg & (ex_rd != 5'd0) &
                      ((id_uses_rs & (id_rs == ex_rd)) | (id_uses_rt & (id_rt == ex_rd)));

    assign dbg_state = state_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        bubble     = 1'b0;
        flush_ifid = 1'b0;
        freeze     = 1'b0;
        bus_error  = 1'b0;
        if (!reset) begin
            unique case (state_q)
                RUN: begin
                    if (mem_wait) begin
                        freeze     = 1'b1;
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        state_d    = WAIT_MEM;
                        wait_cnt_d = CW'(1);
                    end else if (load_use) begin
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        bubble    = 1'b1;
                        state_d   = STALL_LU;
                    end else if (branch_taken) begin
                        flush_ifid = 1'b1;
                    end
                end
                STALL_LU: begin
                    // EX already holds the bubble, so load_use is stale here.
                    if (mem_wait) begin
                        freeze     = 1'b1;
                        PCWrite    = 1'b0;
                        IFIDWrite  = 1'b0;
                        state_d    = WAIT_MEM;
                        wait_cnt_d = CW'(1);
                    end else begin
                        flush_ifid = branch_taken;
                        state_d    = RUN;
                    end
                end
                WAIT_MEM: begin
                    if (mem_wait) begin
                        freeze    = 1'b1;
                        PCWrite   = 1'b0;
                        IFIDWrite = 1'b0;
                        if (wait_cnt_q == CW'(MAX_WAIT)) begin
                            bus_error = 1'b1;
                            state_d   = ERROR;
                        end else begin
                            wait_cnt_d = wait_cnt_q + CW'(1);
                        end
                    end else begin
                        // Released this cycle: ID hazards are resolved as in RUN.
                        wait_cnt_d = '0;
                        if (load_use) begin
                            PCWrite   = 1'b0;
                            IFIDWrite = 1'b0;
                            bubble    = 1'b1;
                            state_d   = STALL_LU;
                        end else begin
                            flush_ifid = branch_taken;
                            state_d    = RUN;
                        end
                    end
                end
                ERROR: begin
                    freeze    = 1'b1;
                    PCWrite   = 1'b0;
                    IFIDWrite = 1'b0;
                    bus_error = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q + {31'd0, ~PCWrite};
        flush_cnt_d = flush_cnt_q + {31'd0, flush_ifid};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_count  = flush_cnt_q;
`else
    assign stall_cycles = 32'd0;
    assign flush_count  = 32'd0;
`endif

endmodule
